or16_unit: RTL and testbench



---
 rtl/or16_unit.sv | 71 +++++++
 tb/tb_or16_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/or16_unit.sv
// 16-bit OR unit: combinational a|b plus a registered, valid-qualified copy with zr/ng/popcount flags.
// Define OR16_ACCUM_EN to turn the registered path into a sticky OR accumulator with an acc_clr input.
module or16_unit #(
  parameter int WIDTH = 16,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
`ifdef OR16_ACCUM_EN
  input  logic             acc_clr,
`endif
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  output logic             zr,
  output logic             ng,
  output logic [CW-1:0]    ones
);

  // Per-bit OR kept purely combinational so it never sees register state.
  for (genvar i = 0; i < WIDTH; i++) begin : g_or
    assign out[i] = a[i] | b[i];
  end

  logic [WIDTH-1:0] nxt;
  logic             load;
  logic [CW-1:0]    cnt;

`ifdef OR16_ACCUM_EN
  // Clear happens before the load, so clear+capture yields just a|b.
  always_comb begin
    nxt  = out_q;
    load = in_valid | acc_clr;
    if (acc_clr)  nxt = '0;
    if (in_valid) nxt = nxt | out;
  end
`else
  always_comb begin
    nxt  = out;
    load = in_valid;
  end
`endif

  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) cnt = cnt + CW'(nxt[i]);
  end

  // Flags are derived from the next value so they land on the same edge as out_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      out_valid <= 1'b0;
      zr        <= 1'b1;
      ng        <= 1'b0;
      ones      <= '0;
    end else begin
      out_valid <= in_valid;
      if (load) begin
        out_q <= nxt;
        zr    <= ~|nxt;
        ng    <= nxt[WIDTH-1];
        ones  <= cnt;
      end
    end
  end

endmodule

// File: tb/tb_or16_unit.sv
// Bench for or16_unit: directed vector tables, randomized traffic against a behavioural model,
// and the accumulator sequence when OR16_ACCUM_EN is defined.
module tb_or16_unit;
  logic        clk = 1'b0, clk_en = 1'b0;
  logic        rst = 1'b0, in_valid = 1'b0;
  logic [15:0] a = '0, b = '0;
`ifdef OR16_ACCUM_EN
  logic        acc_clr = 1'b0;
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif
  logic [15:0] out, out_q;
  logic        out_valid, zr, ng;
  logic [4:0]  ones;

  or16_unit #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
`ifdef OR16_ACCUM_EN
    .acc_clr(acc_clr),
`endif
    .out(out), .out_q(out_q), .out_valid(out_valid), .zr(zr), .ng(ng), .ones(ones)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int errors = 0, checks = 0;
  logic [15:0] mq;
  logic        mv;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference: registered state described directly by the rules, flags derived with $countones.
  task automatic model_edge(input logic r, iv, cl, input logic [15:0] aa, bb);
    if (r) begin
      mq = 16'h0; mv = 1'b0;
    end else begin
      mv = iv;
      if (ACC && cl) mq = 16'h0;
      if (iv) mq = ACC ? (mq | aa | bb) : (aa | bb);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".out_q"}, out_q, mq);
    chk({tag, ".out_valid"}, out_valid, mv);
    chk({tag, ".zr"}, zr, mq == 16'h0);
    chk({tag, ".ng"}, ng, mq[15]);
    chk({tag, ".ones"}, ones, $countones(mq));
  endtask

  task automatic cyc(input logic r, iv, cl, input logic [15:0] aa, bb);
    @(negedge clk);
    rst = r; in_valid = iv; a = aa; b = bb;
`ifdef OR16_ACCUM_EN
    acc_clr = cl;
`endif
    #1 chk("out_live", out, aa | bb);
    @(posedge clk);
    model_edge(r, iv, cl, aa, bb);
    #1;
  endtask

  typedef struct { logic [15:0] a, b, o; } comb_vec_t;
  typedef struct {
    logic r, iv; logic [15:0] a, b, q; logic v, zr, ng; logic [4:0] ones;
  } reg_vec_t;

  comb_vec_t cv[4];
  reg_vec_t  rv[8];

  initial begin
    cv[0] = '{16'h0000, 16'h0000, 16'h0000};
    cv[1] = '{16'hFFFF, 16'h0000, 16'hFFFF};
    cv[2] = '{16'hAAAA, 16'h5555, 16'hFFFF};
    cv[3] = '{16'h1200, 16'h0034, 16'h1234};
    //         r  iv  a         b         q         v  zr ng ones
    rv[0] = '{1, 0, 16'h1234, 16'h0001, 16'h0000, 0, 1, 0, 5'd0};
    rv[1] = '{0, 1, 16'h8000, 16'h0001, 16'h8001, 1, 0, 1, 5'd2};
    rv[2] = '{0, 0, 16'h0000, 16'h0000, 16'h8001, 0, 0, 1, 5'd2};
    rv[3] = '{0, 1, 16'h00F0, 16'h000F, 16'h00FF, 1, 0, 0, 5'd8};
    rv[4] = '{0, 1, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 5'd0};
    rv[5] = '{0, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 0, 1, 5'd16};
    rv[6] = '{1, 1, 16'h0F0F, 16'h0000, 16'h0000, 0, 1, 0, 5'd0};
    rv[7] = '{0, 0, 16'h0101, 16'h0101, 16'h0000, 0, 1, 0, 5'd0};

    // Combinational path with no clock and no reset ever applied.
    for (int i = 0; i < 4; i++) begin
      a = cv[i].a; b = cv[i].b;
      #10 chk($sformatf("comb[%0d]", i), out, cv[i].o);
    end

    clk_en = 1'b1;
    mq = 16'h0; mv = 1'b0;

`ifndef OR16_ACCUM_EN
    for (int i = 0; i < 8; i++) begin
      cyc(rv[i].r, rv[i].iv, 1'b0, rv[i].a, rv[i].b);
      chk($sformatf("vec[%0d].q", i), out_q, rv[i].q);
      chk($sformatf("vec[%0d].v", i), out_valid, rv[i].v);
      chk($sformatf("vec[%0d].zr", i), zr, rv[i].zr);
      chk($sformatf("vec[%0d].ng", i), ng, rv[i].ng);
      chk($sformatf("vec[%0d].ones", i), ones, rv[i].ones);
    end
`else
    cyc(1, 0, 0, 16'h0, 16'h0);
    chk_model("acc_rst");
    cyc(0, 1, 0, 16'h0001, 16'h0000);
    cyc(0, 1, 0, 16'h0100, 16'h0000);
    chk("acc_sticky.q", out_q, 16'h0101);
    chk("acc_sticky.ones", ones, 5'd2);
    cyc(0, 1, 1, 16'h0010, 16'h0000);
    chk("acc_clrload.q", out_q, 16'h0010);
    chk("acc_clrload.v", out_valid, 1'b1);
    cyc(0, 0, 1, 16'h0000, 16'h0000);
    chk("acc_clr.q", out_q, 16'h0000);
    chk("acc_clr.v", out_valid, 1'b0);
    chk("acc_clr.zr", zr, 1'b1);
    cyc(0, 1, 0, 16'h0F00, 16'h0000);
    cyc(1, 1, 0, 16'h00F0, 16'h0000);
    chk("acc_rstprio.q", out_q, 16'h0000);
    chk("acc_rstprio.v", out_valid, 1'b0);
`endif

    // Hand sequence: reset while a capture is offered, then the capture right after.
    cyc(0, 1, 0, 16'hFFFF, 16'h0000);
    cyc(1, 1, 0, 16'h1234, 16'h0001);
    chk_model("rst_drop");
    cyc(0, 1, 0, 16'h8000, 16'h7FFF);
    chk_model("post_rst");

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      logic [15:0] ra, rb;
      int sel;
      sel = $urandom_range(0, 9);
      ra = (sel == 0) ? 16'h0 : (sel == 1) ? 16'hFFFF : 16'($urandom);
      rb = (sel == 0) ? 16'h0 : 16'($urandom) & 16'($urandom);
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 5) == 0, ra, rb);
      chk_model($sformatf("rnd[%0d]", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
